// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity modes, LED policies,
// receiver state encoding and the clocks-per-bit helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int MODE_LATCH  = 0;
  localparam int MODE_TOGGLE = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchronizer, frame FSM and registered result strobes.
// accept/word expose the good-frame decision one cycle early so the LED bank can load alongside rx_valid.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 12000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PAR_NONE
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 UART_RX,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy,
  output logic                 accept,
  output logic [DATA_BITS-1:0] word,
  output rx_state_t            state_dbg
);

  localparam int CPB   = clks_per_bit(CLK_HZ, BAUD);
  localparam int CNT_W = $clog2(CPB + 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CPB / 2 - 1);
  localparam logic [3:0]       LAST_BIT = 4'(DATA_BITS - 1);

  rx_state_t            state;
  logic [1:0]           sync;
  logic                 rx_s;
  logic                 rx_d;
  logic [CNT_W-1:0]     clk_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;
  logic                 full;

  assign rx_s      = sync[1];
  assign full      = (clk_cnt == FULL_M1);
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;
  assign word      = shreg;
  assign accept    = (state == ST_STOP) && full && rx_s && !par_bad;

  // Strobes carry no ready: rx_data is valid on the rx_valid cycle and holds until the next good frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      sync       <= 2'b11;
      rx_d       <= 1'b1;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync       <= {sync[0], UART_RX};
      rx_d       <= rx_s;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_d && !rx_s) begin
            state   <= ST_START;
            clk_cnt <= '0;
            bit_cnt <= '0;
            par_bad <= 1'b0;
          end
        end
        ST_START: begin
          if (clk_cnt == HALF_M1) begin
            clk_cnt <= '0;
            state   <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (full) begin
            clk_cnt <= '0;
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT)
              state <= (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        ST_PAR: begin
          if (full) begin
            clk_cnt <= '0;
            par_bad <= (PARITY == PAR_ODD) ? ~(^shreg ^ rx_s) : (^shreg ^ rx_s);
            state   <= ST_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (full) begin
            clk_cnt <= '0;
            if (!rx_s) begin
              // A framing error outranks a parity error on the same word.
              frame_err <= 1'b1;
              state     <= ST_WAIT_IDLE;
            end else begin
              if (par_bad) begin
                parity_err <= 1'b1;
              end else begin
                rx_valid <= 1'b1;
                rx_data  <= shreg;
              end
              state <= ST_IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          if (!rx_s) begin
            clk_cnt <= '0;
          end else if (full) begin
            clk_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_led_rx.sv
// UART-driven LED bank: receives words and either latches or XOR-toggles them
// onto the LEDs, in the same cycle rx_valid is raised.
module uart_led_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 12000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PAR_NONE,
  parameter int LED_W     = 8,
  parameter int MODE      = MODE_LATCH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 UART_RX,
  output logic [LED_W-1:0]     led,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy,
  output rx_state_t            state_dbg
);

  logic                 accept;
  logic [DATA_BITS-1:0] word;
  logic [LED_W-1:0]     word_led;

  uart_rx_core #(
    .CLK_HZ   (CLK_HZ),
    .BAUD     (BAUD),
    .DATA_BITS(DATA_BITS),
    .PARITY   (PARITY)
  ) u_core (
    .CLK       (CLK),
    .RST       (RST),
    .UART_RX   (UART_RX),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .busy      (busy),
    .accept    (accept),
    .word      (word),
    .state_dbg (state_dbg)
  );

  // Size cast zero-extends a narrow word and keeps the LSBs of a wide one.
  assign word_led = LED_W'(word);

  always_ff @(posedge CLK) begin
    if (RST) begin
      led <= '0;
    end else if (accept) begin
      if (MODE == MODE_TOGGLE) led <= led ^ word_led;
      else                     led <= word_led;
    end
  end

endmodule

// File: tb/tb_uart_led_rx.sv
// Directed bench for uart_led_rx: four parameterisations share one clock,
// each fed its own serial line with hand-computed expected results.
module tb_uart_led_rx;
  import uart_pkg::*;

  localparam int CPB = 104;

  logic       clk;
  logic       rst;
  logic [3:0] rxl;
  int         cyc;

  logic [7:0] led_d, rxd_d;  logic rv_d, pe_d, fe_d, busy_d;  rx_state_t st_d;
  logic [7:0] led_t, rxd_t;  logic rv_t, pe_t, fe_t, busy_t;  rx_state_t st_t;
  logic [7:0] led_p, rxd_p;  logic rv_p, pe_p, fe_p, busy_p;  rx_state_t st_p;
  logic [3:0] led_w;  logic [8:0] rxd_w;  logic rv_w, pe_w, fe_w, busy_w;  rx_state_t st_w;

  int n_checks = 0;
  int n_errs   = 0;
  int nv[4], npe[4], nfe[4];
  int viol = 0;
  logic [2:0] fl[4];
  logic [2:0] fl_q[4];

  uart_led_rx u_def (
    .CLK(clk), .RST(rst), .UART_RX(rxl[0]), .led(led_d), .rx_data(rxd_d),
    .rx_valid(rv_d), .parity_err(pe_d), .frame_err(fe_d), .busy(busy_d), .state_dbg(st_d));

  uart_led_rx #(.MODE(1)) u_tog (
    .CLK(clk), .RST(rst), .UART_RX(rxl[1]), .led(led_t), .rx_data(rxd_t),
    .rx_valid(rv_t), .parity_err(pe_t), .frame_err(fe_t), .busy(busy_t), .state_dbg(st_t));

  uart_led_rx #(.PARITY(2)) u_par (
    .CLK(clk), .RST(rst), .UART_RX(rxl[2]), .led(led_p), .rx_data(rxd_p),
    .rx_valid(rv_p), .parity_err(pe_p), .frame_err(fe_p), .busy(busy_p), .state_dbg(st_p));

  uart_led_rx #(.DATA_BITS(9), .LED_W(4)) u_w9 (
    .CLK(clk), .RST(rst), .UART_RX(rxl[3]), .led(led_w), .rx_data(rxd_w),
    .rx_valid(rv_w), .parity_err(pe_w), .frame_err(fe_w), .busy(busy_w), .state_dbg(st_w));

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters and strobe exclusivity monitor
  assign fl[0] = {rv_d, pe_d, fe_d};
  assign fl[1] = {rv_t, pe_t, fe_t};
  assign fl[2] = {rv_p, pe_p, fe_p};
  assign fl[3] = {rv_w, pe_w, fe_w};

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst) begin
        nv[i]  += int'(fl[i][2]);
        npe[i] += int'(fl[i][1]);
        nfe[i] += int'(fl[i][0]);
        if ($countones(fl[i]) > 1 || (fl[i] != 3'b000 && fl_q[i] != 3'b000)) viol++;
      end
      fl_q[i] = fl[i];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input int ln, input logic b, input int n);
    rxl[ln] = b;
    wait_clks(n);
  endtask

  task automatic send_frame(input int ln, input logic [8:0] d, input int nd,
                            input logic has_par, input logic pbit, input logic stopb);
    drive_bit(ln, 1'b0, CPB);
    for (int i = 0; i < nd; i++) drive_bit(ln, d[i], CPB);
    if (has_par) drive_bit(ln, pbit, CPB);
    drive_bit(ln, stopb, CPB);
  endtask

  initial begin
    int   t0, lat, v_before;
    logic got;
    logic [7:0] rst_word;
    for (int i = 0; i < 4; i++) begin
      nv[i] = 0; npe[i] = 0; nfe[i] = 0; fl_q[i] = 3'b000;
    end
    cyc = 0;
    rst = 1'b1;
    rxl = 4'hF;
    wait_clks(5);

    check_eq("rst_led",        32'(led_d), 0);
    check_eq("rst_rx_data",    32'(rxd_d), 0);
    check_eq("rst_rx_valid",   32'(rv_d), 0);
    check_eq("rst_parity_err", 32'(pe_d), 0);
    check_eq("rst_frame_err",  32'(fe_d), 0);
    check_eq("rst_busy",       32'(busy_d), 0);
    check_eq("rst_state",      32'(st_d), 32'(ST_IDLE));
    rst = 1'b0;
    wait_clks(10);

    // 8N1 0xA5: valid expected 9.5*104+3 = 991 clocks after the start edge
    t0  = cyc;
    got = 1'b0;
    lat = 0;
    fork
      send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1);
      begin
        for (int i = 0; i < 1200 && !got; i++) begin
          @(negedge clk);
          if (rv_d) begin
            got = 1'b1;
            lat = cyc - t0;
          end
        end
      end
    join
    wait_clks(20);
    check_eq("a5_valid_seen", 32'(got), 1);
    check_eq("a5_latency_near_991", 32'(lat >= 988 && lat <= 994), 1);
    check_eq("a5_rx_data", 32'(rxd_d), 32'h0A5);
    check_eq("a5_led", 32'(led_d), 32'h0A5);
    check_eq("a5_valid_count", nv[0], 1);
    check_eq("a5_busy_after", 32'(busy_d), 0);

    // Back-to-back frames
    send_frame(0, 9'h012, 8, 1'b0, 1'b0, 1'b1);
    send_frame(0, 9'h034, 8, 1'b0, 1'b0, 1'b1);
    wait_clks(20);
    check_eq("b2b_valid_count", nv[0], 3);
    check_eq("b2b_rx_data", 32'(rxd_d), 32'h034);
    check_eq("b2b_led", 32'(led_d), 32'h034);

    // 0x55 with stop bit low, line held low three more bit times
    send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1'b0);
    wait_clks(3 * CPB);
    check_eq("ferr_busy_while_low", 32'(busy_d), 1);
    rxl[0] = 1'b1;
    wait_clks(60);
    check_eq("ferr_busy_half_bit_high", 32'(busy_d), 1);
    wait_clks(70);
    check_eq("ferr_idle_after_bit_high", 32'(busy_d), 0);
    check_eq("ferr_count", nfe[0], 1);
    check_eq("ferr_no_valid", nv[0], 3);
    check_eq("ferr_no_pe", npe[0], 0);
    check_eq("ferr_rx_data_kept", 32'(rxd_d), 32'h034);

    // 40-clock glitch on an idle line
    rxl[0] = 1'b0;
    wait_clks(20);
    check_eq("glitch_busy_mid", 32'(busy_d), 1);
    wait_clks(20);
    rxl[0] = 1'b1;
    wait_clks(200);
    check_eq("glitch_back_idle", 32'(busy_d), 0);
    check_eq("glitch_no_valid", nv[0], 3);
    check_eq("glitch_no_fe", nfe[0], 1);

    // XOR-toggle LED policy
    send_frame(1, 9'h00F, 8, 1'b0, 1'b0, 1'b1);
    wait_clks(20);
    check_eq("tog_led_0f", 32'(led_t), 32'h0F);
    send_frame(1, 9'h0FF, 8, 1'b0, 1'b0, 1'b1);
    wait_clks(20);
    check_eq("tog_led_f0", 32'(led_t), 32'hF0);
    check_eq("tog_valid_count", nv[1], 2);

    // Even parity: 0x5A with parity 0 is good, 0x03 with parity 1 is bad
    send_frame(2, 9'h05A, 8, 1'b1, 1'b0, 1'b1);
    wait_clks(20);
    check_eq("par_good_rx_data", 32'(rxd_p), 32'h05A);
    check_eq("par_good_led", 32'(led_p), 32'h05A);
    send_frame(2, 9'h003, 8, 1'b1, 1'b1, 1'b1);
    wait_clks(20);
    check_eq("par_err_count", npe[2], 1);
    check_eq("par_err_rx_data_kept", 32'(rxd_p), 32'h05A);
    check_eq("par_err_led_kept", 32'(led_p), 32'h05A);
    check_eq("par_valid_count", nv[2], 1);
    check_eq("par_no_fe", nfe[2], 0);

    // 9 data bits into a 4-bit LED bank
    send_frame(3, 9'h1A7, 9, 1'b0, 1'b0, 1'b1);
    wait_clks(20);
    check_eq("w9_rx_data", 32'(rxd_w), 32'h1A7);
    check_eq("w9_led", 32'(led_w), 32'h7);
    check_eq("w9_valid_count", nv[3], 1);

    // Reset in the middle of data bit 4 of 0xC3
    rst_word = 8'hC3;
    drive_bit(0, 1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(0, rst_word[i], CPB);
    rxl[0] = rst_word[4];
    wait_clks(50);
    check_eq("pre_rst_in_data", 32'(st_d), 32'(ST_DATA));
    rst = 1'b1;
    rxl[0] = 1'b1;
    wait_clks(3);
    check_eq("mid_rst_led", 32'(led_d), 0);
    check_eq("mid_rst_rx_data", 32'(rxd_d), 0);
    check_eq("mid_rst_rx_valid", 32'(rv_d), 0);
    check_eq("mid_rst_parity_err", 32'(pe_d), 0);
    check_eq("mid_rst_frame_err", 32'(fe_d), 0);
    check_eq("mid_rst_busy", 32'(busy_d), 0);
    rst = 1'b0;
    wait_clks(20);
    check_eq("post_rst_idle", 32'(busy_d), 0);
    v_before = nv[0];
    send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1'b1);
    wait_clks(20);
    check_eq("post_rst_rx_data", 32'(rxd_d), 32'h03C);
    check_eq("post_rst_led", 32'(led_d), 32'h03C);
    check_eq("post_rst_one_valid", nv[0], v_before + 1);
    check_eq("post_rst_no_new_fe", nfe[0], 1);

    check_eq("strobes_exclusive_nonconsecutive", viol, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
